// File: rtl/iter_counter.sv
// Parametrised iteration counter for the mult-div datapath: programmable terminal
// count, up/down direction, start/busy/done handshake, synchronous load and abort.
module iter_counter #(
    parameter int                 WIDTH   = 6,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             up,
    input  logic [WIDTH-1:0] term,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             at_target;

    assign at_target = (count_q == target_q);

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        dir_d    = dir_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = RST_VAL;
        end else if (state_q == IDLE && start) begin
            state_d = RUN;
            dir_d   = up;
            if (up) begin
                count_d  = '0;
                target_d = term;
            end else begin
                count_d  = term;
                target_d = '0;
            end
        end else if (load) begin
            count_d = load_val;
        end else if (state_q == RUN && ena) begin
            if (at_target) begin
                // Final iteration: count parks on target, done pulses next cycle.
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (dir_q) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            count_q  <= RST_VAL;
            target_q <= '0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign last  = busy & ena & at_target;

endmodule

// File: tb/tb_iter_counter.sv
// Self-checking bench for iter_counter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the counter.
module tb_iter_counter;

    localparam int         WIDTH   = 6;
    localparam logic [5:0] RST_VAL = 6'd0;

    logic             clk = 1'b0;
    logic             clrn;
    logic             start, up, ena, load, abort;
    logic [WIDTH-1:0] term, load_val;
    logic [WIDTH-1:0] count;
    logic             busy, last, done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_run;
    bit [5:0] m_count;
    bit [5:0] m_target;
    bit       m_up;
    bit       m_done;

    iter_counter #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .up       (up),
        .term     (term),
        .ena      (ena),
        .load     (load),
        .load_val (load_val),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .last     (last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run    = 1'b0;
        m_count  = RST_VAL;
        m_target = '0;
        m_up     = 1'b1;
        m_done   = 1'b0;
    endfunction

    // One clock edge of the counter's documented behaviour, in priority order.
    function automatic void model_step(input bit s, input bit u, input bit [5:0] t,
                                       input bit e, input bit l, input bit [5:0] lv,
                                       input bit a);
        bit fin;
        fin = 1'b0;
        if (a) begin
            m_run   = 1'b0;
            m_count = RST_VAL;
        end else if (!m_run && s) begin
            m_run    = 1'b1;
            m_up     = u;
            m_target = u ? t : 6'd0;
            m_count  = u ? 6'd0 : t;
        end else if (l) begin
            m_count = lv;
        end else if (m_run && e) begin
            if (m_count == m_target) begin
                m_run = 1'b0;
                fin   = 1'b1;
            end else begin
                m_count = 6'((int'(m_count) + (m_up ? 1 : 63)) % 64);
            end
        end
        m_done = fin;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit s, input bit u, input bit [5:0] t, input bit e,
                         input bit l, input bit [5:0] lv, input bit a);
        start = s; up = u; term = t; ena = e; load = l; load_val = lv; abort = a;
        @(negedge clk);
        check("count", count, m_count);
        check("busy",  busy,  m_run);
        check("done",  done,  m_done);
        check("last",  last,  m_run && e && (m_count == m_target));
        @(posedge clk);
        model_step(s, u, t, e, l, lv, a);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ena_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0, 0, 0);
    endtask

    // Enable until the model reports done, bounded so a stuck DUT cannot hang us.
    task automatic run_to_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!m_done && k < budget) begin
            cycle(0, 0, 0, 1, 0, 0, 0);
            k++;
        end
        check({tag, "_finished"}, m_done, 1'b1);
    endtask

    // Drop clrn between edges and check the outputs clear before the next edge.
    task automatic async_reset_mid(input string tag);
        #2 clrn = 1'b0;
        #1;
        check({tag, "_count"}, count, RST_VAL);
        check({tag, "_busy"},  busy,  1'b0);
        check({tag, "_done"},  done,  1'b0);
        model_reset();
        @(posedge clk);
        #1 clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b0;
        start = 0; up = 0; term = '0; ena = 0; load = 0; load_val = '0; abort = 0;
        model_reset();
        #3;
        check("rst_count", count, RST_VAL);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_last",  last,  1'b0);
        @(posedge clk);
        #1 clrn = 1'b1;

        // 1: full-length up run
        idle_cycle();
        cycle(1, 1, 31, 0, 0, 0, 0);
        ena_cycles(32);
        check("t1_done",  done,  1'b1);
        check("t1_busy",  busy,  1'b0);
        check("t1_count", count, 6'd31);
        idle_cycle();
        idle_cycle();

        // 2: down run with stalls
        cycle(1, 0, 5, 0, 0, 0, 0);
        begin
            bit ena_pat [8] = '{1, 0, 1, 1, 0, 1, 1, 1};
            for (int i = 0; i < 8; i++) cycle(0, 0, 0, ena_pat[i], 0, 0, 0);
        end
        check("t2_done",  done,  1'b1);
        check("t2_count", count, 6'd0);
        idle_cycle();

        // 3: single-iteration run, then load past target and wrap
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("t3a_done", done, 1'b1);
        idle_cycle();
        cycle(1, 1, 2, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 62, 0);
        ena_cycles(5);
        check("t3b_done",  done,  1'b1);
        check("t3b_count", count, 6'd2);
        idle_cycle();

        // 4: abort mid-run, then async reset mid-run
        cycle(1, 1, 20, 0, 0, 0, 0);
        ena_cycles(7);
        cycle(0, 0, 0, 1, 0, 0, 1);
        check("t4_abort_busy",  busy,  1'b0);
        check("t4_abort_count", count, 6'd0);
        idle_cycle();
        cycle(1, 1, 20, 0, 0, 0, 0);
        ena_cycles(9);
        check("t4_pre_rst_count", count, 6'd9);
        async_reset_mid("t4_async");
        idle_cycle();
        idle_cycle();

        // 5: start while busy is ignored; back-to-back start in the done cycle
        cycle(1, 1, 10, 0, 0, 0, 0);
        ena_cycles(3);
        cycle(1, 0, 3, 1, 0, 0, 0);
        run_to_done("t5a", 40);
        cycle(1, 1, 3, 0, 0, 0, 0);
        check("t5_busy_again", busy, 1'b1);
        ena_cycles(4);
        check("t5b_done", done, 1'b1);
        idle_cycle();

        // 6: priority corners
        cycle(1, 1, 20, 0, 0, 0, 0);
        ena_cycles(3);
        cycle(0, 0, 0, 1, 1, 17, 1);
        check("t6_abort_count", count, 6'd0);
        check("t6_abort_busy",  busy,  1'b0);
        cycle(1, 1, 20, 0, 0, 0, 0);
        ena_cycles(2);
        cycle(0, 0, 0, 1, 1, 9, 0);
        check("t6_load_count", count, 6'd9);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1, 33, 0);
        check("t6_idle_load_count", count, 6'd33);
        check("t6_idle_load_busy",  busy,  1'b0);
        idle_cycle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit       s, u, e, l, a;
            bit [5:0] t, lv;
            s  = ($urandom_range(0, 99) < 30);
            u  = $urandom_range(0, 1);
            t  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            e  = ($urandom_range(0, 99) < 75);
            l  = ($urandom_range(0, 99) < 4);
            lv = 6'($urandom_range(0, 63));
            a  = ($urandom_range(0, 99) < 2);
            cycle(s, u, t, e, l, lv, a);
            if (i % 997 == 500) async_reset_mid("rnd_async");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iter_counter.md
Name: iter_counter

Overview:
Parametrised iteration counter for the mult-div datapath. It generalises the fixed 4-bit enable counter to any width, with a programmable terminal count and up or down direction. It adds a start/busy/done handshake, synchronous load and abort, and a final-iteration flag. The multiplier and divider control FSMs use it to sequence N-cycle operations, for example 32 iterations with term=31.

Parameters:
WIDTH, 6, counter and terminal-count width in bits; count wraps modulo 2^WIDTH.
RST_VAL, 0, value of count after async reset and after abort.

Ports:
clk  input  1  rising-edge clock
clrn  input  1  asynchronous active-low clear; forces reset state immediately
start  input  1  begin a run; honoured only in IDLE
up  input  1  direction, sampled with start: 1 = count up, 0 = count down
term  input  WIDTH  terminal value, sampled with start
ena  input  1  advance enable; one iteration per cycle with ena=1 in RUN
load  input  1  synchronous load of load_val into count
load_val  input  WIDTH  value written by load
abort  input  1  synchronous cancel of current run
count  output  WIDTH  current iteration value (registered)
busy  output  1  high while in RUN (registered)
last  output  1  combinational: busy & ena & (count == target); current cycle is the final iteration
done  output  1  registered one-cycle pulse after the final iteration

Behaviour:
- Internal registers: state, count, target, dir, done. States: IDLE and RUN.
- Reset (clrn=0, asynchronous, at any time including mid-run):
  - state=IDLE, count=RST_VAL, target=0, dir=1, busy=0, done=0.
  - Outputs take these values without waiting for a clock edge.
- Per-edge priority: clrn > abort > start (IDLE only) > load > ena.
- IDLE, start=1:
  - state<=RUN.
  - up=1: dir<=1, count<=0, target<=term.
  - up=0: dir<=0, count<=term, target<=0.
  - load and ena in the same cycle are ignored.
- IDLE, start=0:
  - load=1: count<=load_val.
  - Otherwise count holds. ena has no effect.
- RUN, abort=1: state<=IDLE, count<=RST_VAL, done stays 0, no done pulse.
- RUN, load=1: count<=load_val; state unchanged; ena ignored that cycle.
- RUN, ena=1, count==target (last=1):
  - state<=IDLE; count holds at target.
  - done<=1 for exactly the next cycle.
- RUN, ena=1, count!=target: count<=count+1 if dir=1, else count-1.
  - Arithmetic is modulo 2^WIDTH: up wraps 2^WIDTH-1 -> 0, down wraps 0 -> 2^WIDTH-1.
  - A load_val past target therefore wraps around until it meets target.
- RUN, ena=0: everything holds; last=0.
- start while busy is ignored; term and up are not re-sampled mid-run.
- Run length: exactly term+1 enabled cycles in either direction, absent load/abort.
  - term=0 gives a single-iteration run: last=1 on the first enabled RUN cycle.
- Latency: busy rises the cycle after start; done rises the cycle after the last=1 cycle, together with busy falling.
- done: 1 in the single cycle after completion, 0 otherwise; cleared by abort or reset.
- Back-to-back: start asserted in the cycle done=1 (state already IDLE) is accepted; busy returns to 1 the next cycle.
- No combinational path from any input to count, busy or done. last depends combinationally on ena only.

Test Plan:
1. Up run, full length: WIDTH=6, clrn pulse low, start=1 up=1 term=31, ena held 1 -> count steps 0..31 over 32 cycles; last=1 only when count=31; next cycle done=1, busy=0, count=31; following cycle done=0.
2. Down run with stalls: start up=0 term=5, ena toggled 1,0,1,1,0,1,1,1 -> count 5,4,4,3,2,2,1,0; last=1 only on the ena=1 cycle at count=0; done one cycle later; count never changes while ena=0.
3. Degenerate and wrap: start term=0 up=1, ena=1 -> last=1 on first RUN cycle, done next cycle. Then start up=1 term=2, load load_val=62 in RUN, ena=1 -> count 62,63,0,1,2, then done.
4. Abort and async reset mid-run: start term=20, abort at count=7 -> next cycle busy=0, count=0, no done. Restart; drop clrn between edges at count=9 -> count=0, busy=0 before the next edge; done stays 0.
5. Handshake corners: start asserted during RUN -> ignored, target unchanged. start in the cycle done=1 with term=3 -> new run begins, busy=1 next cycle, second done exactly 4 enabled cycles later.
6. Priority: abort+load+ena together in RUN -> abort wins (count=0, IDLE). load+ena together -> count=load_val, no increment. load in IDLE -> count=load_val, busy stays 0.
